// File: rtl/xup_logic_vector_pipe.sv
// xup_logic_vector_pipe: per-transaction bitwise op unit
// feeding a STAGES-deep valid/ready pipe with bubble collapse.
module xup_logic_vector_pipe #(
  parameter  int SIZE   = 8,
  parameter  int STAGES = 2,
  localparam int OW     = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [2:0]      op,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] y,
  output logic            y_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   occupancy
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  op_e               op_sel;
  logic [SIZE-1:0]   res;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [SIZE-1:0]   data_q [STAGES];
  logic [SIZE-1:0]   data_d [STAGES];
  logic [OW-1:0]     cnt_q;
  logic [OW-1:0]     cnt_d;
  logic              room;
  logic              acc;
  logic              xfer;

  assign op_sel = op_e'(op);

  // Combinational result of the selected operation.
  always_comb begin
    res = '0;
    unique case (op_sel)
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOTA: res = ~a;
      OP_PASS: res = a;
    endcase
  end

  // Advance chain walked from the output back to stage 0;
  // a stage can load when empty or when its content leaves.
  always_comb begin
    adv  = '0;
    load = '0;
    room = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] && room;
      load[k] = !valid_q[k] || adv[k];
      room    = load[k];
    end
    in_ready = room;
  end

  // Next state of each stage; data only moves with a valid source
  // so an emptied last stage keeps showing its last value.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    if (load[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = res;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  // Occupancy tracks accepts minus transfers out.
  always_comb begin
    acc   = in_valid && in_ready;
    xfer  = out_valid && out_ready;
    cnt_d = cnt_q;
    unique case ({acc, xfer})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign y         = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign y_zero    = out_valid && (y == '0);
  assign occupancy = cnt_q;

endmodule

// File: tb/tb_xup_logic_vector_pipe.sv
// Scoreboard bench for xup_logic_vector_pipe at three
// parameter points: 8x2 (main), 8x4 (bubble), 1x1 (corner).
module tb_xup_logic_vector_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lop(logic [63:0] x, logic [63:0] z,
                                      logic [2:0] o, int w);
    logic [63:0] r;
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case (o)
      3'd0:    r = x & z;
      3'd1:    r = ~(x & z);
      3'd2:    r = x | z;
      3'd3:    r = ~(x | z);
      3'd4:    r = x ^ z;
      3'd5:    r = ~(x ^ z);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r & m;
  endfunction

  // main DUT 8x2
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic       iv, ir, yz, ov, ordy;
  logic [1:0] occ;

  xup_logic_vector_pipe #(.SIZE(8), .STAGES(2)) u_dut (
    .clk(clk), .reset_n(rst_n), .a(a), .b(b), .op(op),
    .in_valid(iv), .in_ready(ir), .y(y), .y_zero(yz),
    .out_valid(ov), .out_ready(ordy), .occupancy(occ)
  );

  // 8x4 DUT
  logic [7:0] a4, b4, y4;
  logic [2:0] op4;
  logic       iv4, ir4, yz4, ov4, ordy4;
  logic [2:0] occ4;

  xup_logic_vector_pipe #(.SIZE(8), .STAGES(4)) u_dut4 (
    .clk(clk), .reset_n(rst_n), .a(a4), .b(b4), .op(op4),
    .in_valid(iv4), .in_ready(ir4), .y(y4), .y_zero(yz4),
    .out_valid(ov4), .out_ready(ordy4), .occupancy(occ4)
  );

  // 1x1 DUT
  logic       a1, b1, y1;
  logic [2:0] op1;
  logic       iv1, ir1, yz1, ov1, ordy1;
  logic       occ1;

  xup_logic_vector_pipe #(.SIZE(1), .STAGES(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .a(a1), .b(b1), .op(op1),
    .in_valid(iv1), .in_ready(ir1), .y(y1), .y_zero(yz1),
    .out_valid(ov1), .out_ready(ordy1), .occupancy(occ1)
  );

  // main scoreboard
  logic [7:0] q_m[$];
  int         qc_m[$];
  logic [7:0] got_y[$];
  logic       got_z[$];
  bit         strict = 1'b0;
  bit         hold_m;
  logic [7:0] hold_y;
  int         wd_m;
  logic [7:0] e_m;
  int         c_m;
  logic [63:0] t_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_m.delete();
      qc_m.delete();
      hold_m = 1'b0;
      wd_m   = 0;
    end else begin
      chk("occ", 64'(occ), 64'(q_m.size()));
      chk("in_ready", 64'(ir), 64'((q_m.size() < 2) || ordy));
      if (hold_m) begin
        chk("hold_valid", 64'(ov), 64'd1);
        chk("hold_y", 64'(y), 64'(hold_y));
      end
      hold_m = ov && !ordy;
      hold_y = y;
      if (ov && ordy) begin
        wd_m = 0;
        got_y.push_back(y);
        got_z.push_back(yz);
        if (q_m.size() == 0) begin
          chk("spurious_out", 64'(ov), 64'd0);
        end else begin
          e_m = q_m.pop_front();
          c_m = qc_m.pop_front();
          chk("y", 64'(y), 64'(e_m));
          chk("y_zero", 64'(yz), 64'(e_m == 8'h00));
          if (strict) chk("latency", 64'(cyc + 1 - c_m), 64'd2);
        end
      end else if (q_m.size() > 0 && ordy) begin
        wd_m++;
        if (wd_m > 4) begin
          chk("timeout", 64'(ov), 64'd1);
          wd_m = 0;
        end
      end else begin
        wd_m = 0;
      end
      if (iv && ir) begin
        t_m = lop(64'(a), 64'(b), op, 8);
        q_m.push_back(t_m[7:0]);
        qc_m.push_back(cyc + 1);
      end
    end
  end

  // 8x4 scoreboard
  logic [7:0] q_4[$];
  int         wd_4;
  logic [7:0] e_4;
  logic [63:0] t_4;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_4.delete();
      wd_4 = 0;
    end else begin
      chk("occ4", 64'(occ4), 64'(q_4.size()));
      chk("in_ready4", 64'(ir4), 64'((q_4.size() < 4) || ordy4));
      if (ov4 && ordy4) begin
        wd_4 = 0;
        if (q_4.size() == 0) begin
          chk("spurious_out4", 64'(ov4), 64'd0);
        end else begin
          e_4 = q_4.pop_front();
          chk("y4", 64'(y4), 64'(e_4));
          chk("y_zero4", 64'(yz4), 64'(e_4 == 8'h00));
        end
      end else if (q_4.size() > 0 && ordy4) begin
        wd_4++;
        if (wd_4 > 8) begin
          chk("timeout4", 64'(ov4), 64'd1);
          wd_4 = 0;
        end
      end else begin
        wd_4 = 0;
      end
      if (iv4 && ir4) begin
        t_4 = lop(64'(a4), 64'(b4), op4, 8);
        q_4.push_back(t_4[7:0]);
      end
    end
  end

  // 1x1 scoreboard
  logic        q_1[$];
  int          wd_1;
  logic        e_1;
  logic [63:0] t_1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_1.delete();
      wd_1 = 0;
    end else begin
      chk("occ1", 64'(occ1), 64'(q_1.size()));
      chk("in_ready1", 64'(ir1), 64'((q_1.size() < 1) || ordy1));
      if (ov1 && ordy1) begin
        wd_1 = 0;
        if (q_1.size() == 0) begin
          chk("spurious_out1", 64'(ov1), 64'd0);
        end else begin
          e_1 = q_1.pop_front();
          chk("y1", 64'(y1), 64'(e_1));
          chk("y_zero1", 64'(yz1), 64'(!e_1));
        end
      end else if (q_1.size() > 0 && ordy1) begin
        wd_1++;
        if (wd_1 > 3) begin
          chk("timeout1", 64'(ov1), 64'd1);
          wd_1 = 0;
        end
      end else begin
        wd_1 = 0;
      end
      if (iv1 && ir1) begin
        t_1 = lop(64'(a1), 64'(b1), op1, 1);
        q_1.push_back(t_1[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03,
                            8'h3C, 8'hC3, 8'h0F, 8'hF0};
  logic [7:0] bp_exp [3] = '{8'h3C, 8'hC0, 8'hFC};
  logic [7:0] yz_exp [3] = '{8'h00, 8'h00, 8'hFF};
  logic       yz_flag [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; op = '0; iv = 1'b0; ordy = 1'b1;
    a4 = '0; b4 = '0; op4 = '0; iv4 = 1'b0; ordy4 = 1'b1;
    a1 = '0; b1 = '0; op1 = '0; iv1 = 1'b0; ordy1 = 1'b1;
    #12;
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'd1);
    chk("rst_y_zero", 64'(yz), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // op sweep, back to back
    step();
    strict = 1'b1;
    got_y.delete();
    for (int i = 0; i < 8; i++) begin
      a = 8'hF0; b = 8'hCC; op = 3'(i); iv = 1'b1;
      step();
    end
    iv = 1'b0;
    repeat (4) step();
    strict = 1'b0;
    chk("sweep_count", 64'(got_y.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_y.size(); i++)
      chk($sformatf("sweep_op%0d", i), 64'(got_y[i]), 64'(sweep[i]));

    // back-pressure
    got_y.delete();
    ordy = 1'b0;
    a = 8'hF0; b = 8'hCC; op = 3'd4; iv = 1'b1;
    step();
    op = 3'd0;
    step();
    op = 3'd2;
    step();
    @(negedge clk);
    chk("bp_occ", 64'(occ), 64'd2);
    chk("bp_in_ready", 64'(ir), 64'd0);
    chk("bp_out_valid", 64'(ov), 64'd1);
    chk("bp_y", 64'(y), 64'h3C);
    step();
    step();
    ordy = 1'b1;
    #1;
    chk("bp_in_ready_rise", 64'(ir), 64'd1);
    step();
    iv = 1'b0;
    repeat (5) step();
    chk("bp_count", 64'(got_y.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_y.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(got_y[i]), 64'(bp_exp[i]));

    // y_zero
    got_y.delete();
    got_z.delete();
    a = 8'hAA; b = 8'h55; op = 3'd0; iv = 1'b1;
    step();
    op = 3'd3;
    step();
    op = 3'd2;
    step();
    iv = 1'b0;
    repeat (4) step();
    chk("yz_count", 64'(got_y.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_y.size(); i++) begin
      chk($sformatf("yz_y%0d", i), 64'(got_y[i]), 64'(yz_exp[i]));
      chk($sformatf("yz_flag%0d", i), 64'(got_z[i]), 64'(yz_flag[i]));
    end

    // async reset mid-stream
    ordy = 1'b0;
    a = 8'h5A; op = 3'd7; iv = 1'b1;
    step();
    a = 8'hA5;
    step();
    iv = 1'b0;
    @(negedge clk);
    chk("pre_rst_occ", 64'(occ), 64'd2);
    chk("pre_rst_valid", 64'(ov), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(ov), 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_y", 64'(y), 64'd0);
    chk("arst_in_ready", 64'(ir), 64'd1);
    chk("arst_y_zero", 64'(yz), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    got_y.delete();
    strict = 1'b1;
    ordy = 1'b1;
    a = 8'h3C; b = 8'h0F; op = 3'd4; iv = 1'b1;
    step();
    iv = 1'b0;
    repeat (4) step();
    strict = 1'b0;
    chk("post_rst_count", 64'(got_y.size()), 64'd1);
    if (got_y.size() > 0) chk("post_rst_y", 64'(got_y[0]), 64'h33);

    // bubble collapse on 8x4
    ordy4 = 1'b0;
    a4 = 8'($urandom); b4 = 8'($urandom); op4 = 3'($urandom);
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    @(negedge clk);
    chk("bub_valid_e1", 64'(ov4), 64'd0);
    step();
    step();
    @(negedge clk);
    chk("bub_valid_e3", 64'(ov4), 64'd0);
    step();
    @(negedge clk);
    chk("bub_valid_e4", 64'(ov4), 64'd1);
    for (int i = 0; i < 3; i++) begin
      a4 = 8'($urandom); b4 = 8'($urandom); op4 = 3'($urandom);
      iv4 = 1'b1;
      step();
    end
    iv4 = 1'b0;
    @(negedge clk);
    chk("bub_occ_full", 64'(occ4), 64'd4);
    chk("bub_in_ready", 64'(ir4), 64'd0);
    step();
    ordy4 = 1'b1;
    repeat (8) step();

    // random traffic on 8x2 and 1x1
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      a1 = 1'($urandom); b1 = 1'($urandom); op1 = 3'($urandom);
      iv1 = 1'($urandom);
      ordy1 = 1'($urandom);
      step();
    end
    iv = 1'b0; ordy = 1'b1;
    iv1 = 1'b0; ordy1 = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("drain_main", 64'(q_m.size()), 64'd0);
    chk("drain_4", 64'(q_4.size()), 64'd0);
    chk("drain_1", 64'(q_1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
